// File: rtl/register_file_pkg.sv
// Shared widths and the operand-lookup result type for the register file.
package register_file_pkg;
  localparam int REG_SIZE  = 32;
  localparam int REG_WIDTH = 5;
  localparam int ROB_WIDTH = 4;
  localparam int DATA_W    = 32;
  localparam int NUM_OPS   = 2;

  typedef struct packed {
    logic                 has_dep;
    logic [ROB_WIDTH-1:0] dep;
    logic [DATA_W-1:0]    val;
  } lookup_t;
endpackage

// File: rtl/register_file_lookup.sv
// Per-operand combinational resolve: file value, commit bypass, ROB answer or pending tag.
module register_file_lookup
  import register_file_pkg::*;
(
  input  logic [REG_WIDTH-1:0] rs,
  input  logic                 busy,
  input  logic [ROB_WIDTH-1:0] tag,
  input  logic [DATA_W-1:0]    value,
  input  logic                 rob_ready,
  input  logic [DATA_W-1:0]    rob_data,
  input  logic                 bypass_hit,
  input  logic [DATA_W-1:0]    commit_data,
  output lookup_t              res
);
  always_comb begin
    res = '0;
    if (rs == '0) begin
      res.val = '0;
    end else if (!busy) begin
      res.val = value;
    end else if (bypass_hit) begin
      // a same-cycle commit is newer than anything the ROB lookup reports
      res.val = commit_data;
    end else if (rob_ready) begin
      res.val = rob_data;
    end else begin
      res.has_dep = 1'b1;
      res.dep     = tag;
    end
  end
endmodule

// File: rtl/register_file.sv
// Architectural register file with rename tags, commit write-back and flush.
// Optional REG_COMMIT_BYPASS_EN forwards a same-cycle matching commit to lookups.
module register_file
  import register_file_pkg::*;
#(
  parameter int REG_COUNT = REG_SIZE
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush,
  input  logic [REG_WIDTH-1:0] dec_rs1,
  input  logic [REG_WIDTH-1:0] dec_rs2,
  input  logic                 dec_rdy,
  input  logic [REG_WIDTH-1:0] dec_dest,
  input  logic [ROB_WIDTH-1:0] dec_rob_id,
  output logic [DATA_W-1:0]    dec_val_j,
  output logic [DATA_W-1:0]    dec_val_k,
  output logic [ROB_WIDTH-1:0] dec_dep_j,
  output logic [ROB_WIDTH-1:0] dec_dep_k,
  output logic                 dec_has_dep_j,
  output logic                 dec_has_dep_k,
  output logic [ROB_WIDTH-1:0] reg_rob_id_j,
  output logic [ROB_WIDTH-1:0] reg_rob_id_k,
  input  logic                 reg_ready_j,
  input  logic                 reg_ready_k,
  input  logic [DATA_W-1:0]    reg_data_j,
  input  logic [DATA_W-1:0]    reg_data_k,
  input  logic [REG_WIDTH-1:0] commit_reg_id,
  input  logic [DATA_W-1:0]    commit_data,
  input  logic [ROB_WIDTH-1:0] commit_rob_id
);
  logic [REG_COUNT-1:0][DATA_W-1:0]    value;
  logic [REG_COUNT-1:0]                busy;
  logic [REG_COUNT-1:0][ROB_WIDTH-1:0] tag;

  logic [NUM_OPS-1:0][REG_WIDTH-1:0] rs;
  logic [NUM_OPS-1:0]                rob_ready;
  logic [NUM_OPS-1:0][DATA_W-1:0]    rob_data;
  logic [NUM_OPS-1:0]                hit;
  lookup_t [NUM_OPS-1:0]             res;

  assign rs        = {dec_rs2, dec_rs1};
  assign rob_ready = {reg_ready_k, reg_ready_j};
  assign rob_data  = {reg_data_k, reg_data_j};

  genvar op;
  generate
    for (op = 0; op < NUM_OPS; op++) begin : g_op
`ifdef REG_COMMIT_BYPASS_EN
      assign hit[op] = busy[rs[op]] && (commit_reg_id == rs[op]) && (rs[op] != '0) &&
                       (tag[rs[op]] == commit_rob_id) && !flush;
`else
      assign hit[op] = 1'b0;
`endif
      register_file_lookup u_lookup (
        .rs          (rs[op]),
        .busy        (busy[rs[op]]),
        .tag         (tag[rs[op]]),
        .value       (value[rs[op]]),
        .rob_ready   (rob_ready[op]),
        .rob_data    (rob_data[op]),
        .bypass_hit  (hit[op]),
        .commit_data (commit_data),
        .res         (res[op])
      );
    end
  endgenerate

  assign dec_val_j     = res[0].val;
  assign dec_dep_j     = res[0].dep;
  assign dec_has_dep_j = res[0].has_dep;
  assign dec_val_k     = res[1].val;
  assign dec_dep_k     = res[1].dep;
  assign dec_has_dep_k = res[1].has_dep;
  assign reg_rob_id_j  = tag[dec_rs1];
  assign reg_rob_id_k  = tag[dec_rs2];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      value <= '0;
      busy  <= '0;
      tag   <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        // the ROB is discarding this cycle, so any commit on it is dropped too
        busy <= '0;
      end else begin
        if (commit_reg_id != '0)
          value[commit_reg_id] <= commit_data;
        if (busy[commit_reg_id] && (tag[commit_reg_id] == commit_rob_id))
          busy[commit_reg_id] <= 1'b0;
        // later assignment lets a same-cycle rename win over the retire clear
        if (dec_rdy && (dec_dest != '0)) begin
          busy[dec_dest] <= 1'b1;
          tag[dec_dest]  <= dec_rob_id;
        end
      end
    end
  end
endmodule
